uart_rx_param: RTL
==================

Name: uart_rx_param

Overview:
Parametrised successor to the fixed 8N1 UART receiver. Configurable data width, parity mode, stop-bit count and clocks-per-bit. Adds a valid/ready output handshake with per-word frame, parity and overrun status. Sits between the external serial pin and the command/packet parser; replaces the fixed receiver at the top level.

Parameters:
CLKS_PER_BIT, 868, system clocks per bit (100 MHz / 115200); legal range is 4 or more.
DATA_BITS, 8, data bits per frame; legal range 5..9; sent LSB first.
PARITY_MODE, 0, parity mode: 0 = none, 1 = even, 2 = odd.
STOP_BITS, 1, number of stop bits: 1 or 2.

Ports:
clk  input  1  system clock; all logic on the rising edge
reset_b  input  1  asynchronous, active-low reset
rx_in  input  1  serial line; idles high; asynchronous to clk
data_out  output  DATA_BITS  received word; stable while data_valid=1
data_valid  output  1  data_out and status flags are valid
data_ready  input  1  consumer accepts the word when data_ready=1 and data_valid=1 in the same cycle
frame_err  output  1  word had a low stop bit (any stop bit, if STOP_BITS=2)
parity_err  output  1  parity mismatch; tied 0 when PARITY_MODE=0
overrun  output  1  this word overwrote an untransferred word
busy  output  1  FSM is not in IDLE

Behaviour:
- Reset values: data_out=0, data_valid=0, frame_err=0, parity_err=0, overrun=0, busy=0.
- Input synchroniser: rx_in passes through a 2-flop synchroniser (both flops reset to 1). An edge detector on the synchronised signal flags a 1->0 transition.
- Baud counter: width $clog2(CLKS_PER_BIT). Cleared on every state entry.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: on a synchronised falling edge, go to START.
  - A line held low (break condition) does not retrigger; a 1->0 edge is required.
- START: sample the line at count CLKS_PER_BIT/2-1 (mid-bit).
  - Sample=1: false start; return to IDLE with no output.
  - Sample=0: go to DATA.
- DATA: sample at count CLKS_PER_BIT-1, so each sample is one full bit after the previous mid-bit point.
  - Shift right into a DATA_BITS-wide shift register (LSB first).
  - After DATA_BITS samples, go to PARITY if PARITY_MODE!=0, else go to STOP.
- PARITY: one sample at the same point.
  - Error if XOR(data bits, parity bit) != 0 for even parity, or != 1 for odd parity.
- STOP: STOP_BITS samples. Any stop sample of 0 sets a pending frame error.
  - After the final stop sample, load the output register and return to IDLE in the same cycle. The receiver is then ready for a back-to-back start bit.
- Output register load:
  - data_valid=1 one cycle after the final stop sample.
  - data_out, frame_err and parity_err are written together with data_valid.
  - A frame-error word is still delivered.
- Handshake:
  - data_valid holds until a transfer (data_valid & data_ready). It falls the cycle after the transfer unless a new word loads in that same cycle.
  - data_ready is ignored while data_valid=0.
- Simultaneous transfer and load: the old word transfers, the new word loads, overrun=0.
- Load while data_valid=1 with no transfer: the new word overwrites the old one and overrun=1 for the new word. All flags describe only the currently presented word.
- busy=1 in every state except IDLE.
- Mid-operation reset: reset_b low at any time returns the FSM to IDLE and forces all outputs to their reset values immediately, without waiting for a clock edge.

Optional Feature:
UART_RX_MAJORITY_VOTE_EN
- Defined: each bit (start, data, parity, stop) is a 2-of-3 majority of the synchronised line taken at counts S-1, S and S+1, where S is the normal sample point. The bit decision is made at S+1. Requires CLKS_PER_BIT of 8 or more.
- Undefined: single sample at S; no vote logic is instantiated.

Test Plan:
1. CLKS_PER_BIT=16, 8N1, data_ready=1, send 0xA5 -> data_out=0xA5; data_valid high for exactly 1 cycle, 152-156 cycles after the start edge; all flags 0; busy returns to 0.
2. PARITY_MODE=1, send 0x03 with parity bit=1 -> data_out=0x03, parity_err=1. Resend with parity bit=0 -> parity_err=0. Repeat with PARITY_MODE=2 -> flags inverted.
3. Send 0x55 with stop bit=0, then hold the line low for 40 bit times -> one word with frame_err=1, data_out=0x55; no further data_valid until the line rises and falls again.
4. Pull rx low for 4 cycles, then return high -> FSM returns to IDLE; data_valid never asserts; busy pulses. With the macro defined: a single-cycle glitch at mid-bit of data bit 3 of 0xFF -> data_out=0xFF.
5. data_ready=0, back-to-back frames 0x11 then 0x22 -> data_out=0x22 with overrun=1. Raise data_ready -> data_valid falls the next cycle. Next frame 0x33 -> overrun=0.
6. Assert reset_b low during data bit 4 of 0xC3 -> outputs at reset values immediately; after release, frame 0x3C -> data_out=0x3C with no flags. Repeat with DATA_BITS=7, STOP_BITS=2 and 0x5A -> data_out=0x5A.

Source files
------------

// File: rtl/uart_rx_param_if.sv
// ---------------------------------------------------------------------------
// uart_rx_param_if
//   Output word channel of uart_rx_param: a valid/ready handshake carrying
//   the received word and its per-word status flags.
//
//   Signals:
//     data_out   [DATA_BITS] received word, stable while data_valid=1
//     data_valid             word and flags are valid
//     data_ready             consumer accepts the word (valid & ready)
//     frame_err              word had a low stop bit
//     parity_err             parity mismatch (always 0 with no parity)
//     overrun                this word overwrote an untransferred word
//
//   Modports:
//     master : the receiver (drives the word, samples data_ready)
//     slave  : the consumer (samples the word, drives data_ready)
// ---------------------------------------------------------------------------
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data_out;
  logic                 data_valid;
  logic                 data_ready;
  logic                 frame_err;
  logic                 parity_err;
  logic                 overrun;

  modport master (
    output data_out, data_valid, frame_err, parity_err, overrun,
    input  data_ready
  );

  modport slave (
    input  data_out, data_valid, frame_err, parity_err, overrun,
    output data_ready
  );
endinterface

// File: rtl/uart_rx_param.sv
// ---------------------------------------------------------------------------
// uart_rx_param
//   Parametrised asynchronous serial receiver. Configurable data width
//   (5..9, LSB first), parity (none/even/odd), one or two stop bits and
//   clocks per bit. Received words are presented on a valid/ready channel
//   with frame, parity and overrun status for each word.
//
//   Parameters:
//     CLKS_PER_BIT  system clocks per serial bit (>= 4; >= 8 with voting)
//     DATA_BITS     data bits per frame, 5..9
//     PARITY_MODE   0 = none, 1 = even, 2 = odd
//     STOP_BITS     1 or 2
//
//   Ports:
//     clk      system clock, rising edge
//     reset_b  asynchronous active-low reset
//     rx_in    serial line, idles high, asynchronous to clk
//     busy     receiver FSM is not idle
//     rx_bus   uart_rx_param_if.master output word channel
//
//   Build option:
//     UART_RX_MAJORITY_VOTE_EN  when defined, every bit is a 2-of-3 vote of
//     the line at S-1, S and S+1 around the nominal sample point S, decided
//     at S+1. When undefined, a single sample is taken at S.
// ---------------------------------------------------------------------------
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic            clk,
  input  logic            reset_b,
  input  logic            rx_in,
  output logic            busy,
  uart_rx_param_if.master rx_bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);

`ifdef UART_RX_MAJORITY_VOTE_EN
  // The vote decides one clock after the nominal start sample. Every later
  // decision is counted from that point, so it also lands at S+1.
  localparam int DEC_LAG = 1;
`else
  localparam int DEC_LAG = 0;
`endif

  localparam logic [CW-1:0] START_DEC = CW'(CLKS_PER_BIT / 2 - 1 + DEC_LAG);
  localparam logic [CW-1:0] BIT_DEC   = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  // ---------------------------------------------------------------------
  // Input synchroniser and falling-edge detector
  // ---------------------------------------------------------------------
  logic rx_meta, rx_sync, rx_prev;
  logic rx_fall;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the pre-edge value of its neighbours regardless of order.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // A held-low line gives no edge, so a break cannot retrigger the FSM.
  assign rx_fall = rx_prev & ~rx_sync;

  // ---------------------------------------------------------------------
  // Bit decision
  // ---------------------------------------------------------------------
  state_t          state;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   dec_point;
  logic            at_dec;
  logic            rx_bit;

  assign dec_point = (state == START) ? START_DEC : BIT_DEC;
  assign at_dec    = (cnt == dec_point);

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic vote_a, vote_b;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      vote_a <= 1'b1;
      vote_b <= 1'b1;
    end else if (cnt == dec_point - CW'(2)) begin
      vote_a <= rx_sync;
    end else if (cnt == dec_point - CW'(1)) begin
      vote_b <= rx_sync;
    end
  end

  assign rx_bit = (vote_a & vote_b) | (vote_a & rx_sync) | (vote_b & rx_sync);
`else
  assign rx_bit = rx_sync;
`endif

  // ---------------------------------------------------------------------
  // Receiver FSM with registered output word
  // ---------------------------------------------------------------------
  logic [BW-1:0]        bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 frame_pend;
  logic                 parity_pend;
  logic                 last_stop;

  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 frame_q;
  logic                 parity_q;
  logic                 overrun_q;
  logic                 busy_q;

  assign last_stop = (STOP_BITS == 1) || stop_idx;

  // NOTE: the shift register and output word are reset along with the
  // control state, so data_out reads 0 out of reset rather than X.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      stop_idx    <= 1'b0;
      shreg       <= '0;
      frame_pend  <= 1'b0;
      parity_pend <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_q     <= 1'b0;
      parity_q    <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      // A transfer retires the presented word; a load below in the same
      // cycle takes priority and re-asserts valid.
      if (valid_q && rx_bus.data_ready) begin
        valid_q <= 1'b0;
      end

      cnt <= cnt + 1'b1;

      case (state)
        IDLE: begin
          cnt <= '0;
          if (rx_fall) begin
            state       <= START;
            busy_q      <= 1'b1;
            bit_idx     <= '0;
            stop_idx    <= 1'b0;
            frame_pend  <= 1'b0;
            parity_pend <= 1'b0;
          end
        end

        START: begin
          if (at_dec) begin
            cnt <= '0;
            if (rx_bit) begin
              // Line back high at mid-start: noise, not a frame.
              state  <= IDLE;
              busy_q <= 1'b0;
            end else begin
              state <= DATA;
            end
          end
        end

        DATA: begin
          if (at_dec) begin
            cnt   <= '0;
            shreg <= {rx_bit, shreg[DATA_BITS-1:1]};
            if (bit_idx == LAST_BIT) begin
              state <= (PARITY_MODE != 0) ? PARITY : STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end

        PARITY: begin
          if (at_dec) begin
            cnt         <= '0;
            // Even parity expects an XOR of 0 over data+parity, odd a 1.
            parity_pend <= (^shreg) ^ rx_bit ^ (PARITY_MODE == 2);
            state       <= STOP;
          end
        end

        STOP: begin
          if (at_dec) begin
            cnt <= '0;
            if (last_stop) begin
              data_q    <= shreg;
              frame_q   <= frame_pend | ~rx_bit;
              parity_q  <= parity_pend;
              overrun_q <= valid_q & ~rx_bus.data_ready;
              valid_q   <= 1'b1;
              state     <= IDLE;
              busy_q    <= 1'b0;
            end else begin
              stop_idx   <= 1'b1;
              frame_pend <= frame_pend | ~rx_bit;
            end
          end
        end

        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign rx_bus.data_out   = data_q;
  assign rx_bus.data_valid = valid_q;
  assign rx_bus.frame_err  = frame_q;
  assign rx_bus.parity_err = (PARITY_MODE != 0) ? parity_q : 1'b0;
  assign rx_bus.overrun    = overrun_q;
  assign busy              = busy_q;

endmodule
